dataram_ctrl: RTL and testbench

Initiator-side access sequencer for the MCU51 internal data RAM. Accepts single-operation requests from the CPU core (byte/bit read, byte/bit write, bit complement, byte increment/decrement), decodes 8051 direct and bit addresses, and drives the RAM's chip-select, read/write, byte/bit, address, position and data lines with correct phase. Returns read data and a one-cycle completion pulse. Sits between the instruction execution unit and the internal data RAM.

---
 rtl/dataram_ctrl_if.sv | 23 ++
 rtl/dataram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dataram_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dataram_ctrl_if.sv
// CPU-side request/response bundle of the internal data RAM access sequencer.
interface dataram_ctrl_if;
  logic       req;
  logic [2:0] op;
  logic [7:0] baddr;
  logic [7:0] wdata;
  logic       wbit;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] rdata;
  logic       rbit;

  modport master (
    output req, op, baddr, wdata, wbit,
    input  busy, done, err, rdata, rbit
  );

  modport slave (
    input  req, op, baddr, wdata, wbit,
    output busy, done, err, rdata, rbit
  );
endinterface

// File: rtl/dataram_ctrl.sv
// Internal data RAM access sequencer: decodes 8051 byte/bit addresses and runs
// read, write and read-modify-write cycles on the RAM bus with registered outputs.
module dataram_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dataram_ctrl_if.slave  cpu,
  output logic           ram_CS,
  output logic           ram_RW,
  output logic           ram_Bb,
  output logic [7:0]     ram_addr,
  output logic [7:0]     ram_position,
  output logic [7:0]     ram_din,
  output logic           ram_bin,
  input  logic [7:0]     ram_dout,
  input  logic           ram_bout
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [2:0] OP_BRD = 3'd0;
  localparam logic [2:0] OP_BWR = 3'd1;
  localparam logic [2:0] OP_TRD = 3'd2;
  localparam logic [2:0] OP_TWR = 3'd3;
  localparam logic [2:0] OP_CPL = 3'd4;
  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;
  localparam logic [2:0] LAST   = 3'(RD_LAT - 1);

  function automatic logic [7:0] step_byte(input logic [7:0] v, input logic dn);
    return dn ? (v - 8'd1) : (v + 8'd1);
  endfunction

  state_t      state, state_n;
  logic [2:0]  cnt;
  logic [2:0]  op_q;
  logic        bb_q;
  logic [7:0]  addr_q, pos_q;
  logic        err_q;
  logic [7:0]  rdata_q;
  logic        rbit_q;

  logic [2:0]  c_op;
  logic        c_bb;
  logic [7:0]  c_addr, c_pos;
  logic        fault, accept, rd_last;
  logic [7:0]  wv_byte;
  logic        wv_bit;
  logic        cs_n, rw_n, bb_n, bin_n;
  logic [7:0]  addr_n, pos_n, din_n;

  assign fault   = (cpu.op == OP_RSV) || cpu.baddr[7];
  assign accept  = (state == IDLE) && cpu.req;
  assign rd_last = (cnt == LAST);

  // In IDLE the target comes straight from the request so the first bus
  // cycle can be registered at the accept edge; afterwards it is latched.
  always_comb begin
    c_op   = op_q;
    c_bb   = bb_q;
    c_addr = addr_q;
    c_pos  = pos_q;
    if (state == IDLE) begin
      c_op   = cpu.op;
      c_bb   = !(cpu.op inside {OP_TRD, OP_TWR, OP_CPL});
      c_addr = c_bb ? cpu.baddr : {4'h2, cpu.baddr[6:3]};
      c_pos  = c_bb ? 8'h00 : (8'h01 << cpu.baddr[2:0]);
    end
  end

  // RMW write data is derived from the RAM output at the final RD edge,
  // the same edge that captures it into rdata/rbit.
  always_comb begin
    wv_byte = cpu.wdata;
    if (c_op == OP_INC)      wv_byte = step_byte(ram_dout, 1'b0);
    else if (c_op == OP_DEC) wv_byte = step_byte(ram_dout, 1'b1);
    wv_bit = (c_op == OP_CPL) ? ~ram_bout : cpu.wbit;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (cpu.req) begin
          if (fault)                                 state_n = DONE;
          else if (cpu.op inside {OP_BWR, OP_TWR})  state_n = WR;
          else                                       state_n = RD;
        end
      end
      RD: begin
        if (rd_last) state_n = (op_q inside {OP_BRD, OP_TRD}) ? DONE : WR;
      end
      WR:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cs_n   = 1'b1;
    rw_n   = 1'b1;
    bb_n   = 1'b1;
    addr_n = 8'h00;
    pos_n  = 8'h00;
    din_n  = 8'h00;
    bin_n  = 1'b0;
    if (state_n == RD || state_n == WR) begin
      cs_n   = 1'b0;
      bb_n   = c_bb;
      addr_n = c_addr;
      pos_n  = c_pos;
    end
    if (state_n == WR) begin
      rw_n  = 1'b0;
      din_n = c_bb ? wv_byte : 8'h00;
      bin_n = c_bb ? 1'b0 : wv_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      op_q         <= OP_BRD;
      err_q        <= 1'b0;
      rdata_q      <= 8'h00;
      rbit_q       <= 1'b0;
      ram_CS       <= 1'b1;
      ram_RW       <= 1'b1;
      ram_Bb       <= 1'b1;
      ram_addr     <= 8'h00;
      ram_position <= 8'h00;
      ram_din      <= 8'h00;
      ram_bin      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= (state == RD && state_n == RD) ? cnt + 3'd1 : 3'd0;
      ram_CS       <= cs_n;
      ram_RW       <= rw_n;
      ram_Bb       <= bb_n;
      ram_addr     <= addr_n;
      ram_position <= pos_n;
      ram_din      <= din_n;
      ram_bin      <= bin_n;
      if (accept) begin
        err_q <= fault;
        op_q  <= cpu.op;
      end
      if (state == RD && rd_last) begin
        if (bb_q) rdata_q <= ram_dout;
        else      rbit_q  <= ram_bout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      bb_q   <= c_bb;
      addr_q <= c_addr;
      pos_q  <= c_pos;
    end
  end

  assign cpu.busy  = (state != IDLE);
  assign cpu.done  = (state == DONE);
  assign cpu.err   = err_q;
  assign cpu.rdata = rdata_q;
  assign cpu.rbit  = rbit_q;

endmodule

// File: tb/tb_dataram_ctrl.sv
// Bench for dataram_ctrl: RAM responder, transaction-level expectation model
// checked every cycle, and directed operations with literal expectations.
module tb_dataram_ctrl;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dataram_ctrl_if cpu();
  logic       ram_CS, ram_RW, ram_Bb, ram_bin, ram_bout;
  logic [7:0] ram_addr, ram_position, ram_din, ram_dout;

  dataram_ctrl #(.RD_LAT(RDL)) dut (
    .clk(clk), .rst_n(rst_n), .cpu(cpu),
    .ram_CS(ram_CS), .ram_RW(ram_RW), .ram_Bb(ram_Bb), .ram_addr(ram_addr),
    .ram_position(ram_position), .ram_din(ram_din), .ram_bin(ram_bin),
    .ram_dout(ram_dout), .ram_bout(ram_bout)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM responder plus a recorder of the last write cycle seen on the bus
  logic [7:0] mem [0:255];
  logic       mem_ready = 1'b0;
  int         cs_cnt = 0;
  logic [7:0] wr_addr = 8'h00, wr_pos = 8'h00, wr_din = 8'h00;
  logic       wr_bb = 1'b0, wr_bin = 1'b0;

  assign ram_dout = mem[ram_addr];
  assign ram_bout = |(mem[ram_addr] & ram_position);

  always @(posedge clk) begin
    if (!rst_n && !mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem_ready <= 1'b1;
    end else if (mem_ready) begin
      if (!ram_CS) cs_cnt <= cs_cnt + 1;
      if (!ram_CS && !ram_RW) begin
        if (ram_Bb) mem[ram_addr] <= ram_din;
        else        mem[ram_addr] <= ram_bin ? (mem[ram_addr] | ram_position)
                                             : (mem[ram_addr] & ~ram_position);
        wr_addr <= ram_addr; wr_pos <= ram_position; wr_din <= ram_din;
        wr_bb   <= ram_Bb;   wr_bin <= ram_bin;
      end
    end
  end

  // Expectation model: one queue entry per cycle of an accepted operation
  typedef struct packed {
    logic       cs, rw, bb;
    logic [7:0] addr, pos, din;
    logic       bin, busy, done, err;
    logic [7:0] rdata;
    logic       rbit;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mref [0:255];
  logic       m_err = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_rbit = 1'b0;
  logic       cur_idle = 1'b1;
  logic       rst_seen = 1'b0;

  function automatic exp_t idle_e(input logic busy, input logic done, input logic err);
    exp_t e;
    e.cs = 1'b1; e.rw = 1'b1; e.bb = 1'b1;
    e.addr = 8'h00; e.pos = 8'h00; e.din = 8'h00; e.bin = 1'b0;
    e.busy = busy; e.done = done; e.err = err;
    e.rdata = m_rdata; e.rbit = m_rbit;
    return e;
  endfunction

  task automatic accept_op(input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] wd, input logic wb);
    logic       bitop, obit, vbit, wr;
    logic [7:0] ad, ps, ob, val;
    int         nrd;
    exp_t       e;
    bitop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
    if (op == 3'd7 || a >= 8'h80) begin
      m_err = 1'b1;
      q.push_back(idle_e(1'b1, 1'b1, 1'b1));
    end else begin
      m_err = 1'b0;
      ad   = bitop ? (8'h20 + {4'h0, a[6:3]}) : a;
      ps   = bitop ? (8'h01 << a[2:0]) : 8'h00;
      ob   = mref[ad];
      obit = ob[a[2:0]];
      nrd  = (op == 3'd1 || op == 3'd3) ? 0 : RDL;
      wr   = !(op == 3'd0 || op == 3'd2);
      for (int i = 0; i < nrd; i++) begin
        e = idle_e(1'b1, 1'b0, 1'b0);
        e.cs = 1'b0; e.bb = !bitop; e.addr = ad; e.pos = ps;
        q.push_back(e);
      end
      if (nrd > 0) begin
        if (bitop) m_rbit = obit;
        else       m_rdata = ob;
      end
      if (wr) begin
        case (op)
          3'd1:    val = wd;
          3'd5:    val = ob + 8'd1;
          3'd6:    val = ob - 8'd1;
          default: val = 8'h00;
        endcase
        vbit = (op == 3'd4) ? ~obit : wb;
        e = idle_e(1'b1, 1'b0, 1'b0);
        e.cs = 1'b0; e.rw = 1'b0; e.bb = !bitop; e.addr = ad; e.pos = ps;
        e.din = bitop ? 8'h00 : val;
        e.bin = bitop ? vbit : 1'b0;
        q.push_back(e);
        if (bitop) begin
          ob[a[2:0]] = vbit;
          mref[ad] = ob;
        end else begin
          mref[ad] = val;
        end
      end
      q.push_back(idle_e(1'b1, 1'b1, 1'b0));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        if (!rst_seen) for (int i = 0; i < 256; i++) mref[i] = 8'h00;
        rst_seen = 1'b1;
        q.delete();
        m_err = 1'b0; m_rdata = 8'h00; m_rbit = 1'b0;
      end else if (rst_seen && cpu.req && cur_idle && q.size() == 0) begin
        accept_op(cpu.op, cpu.baddr, cpu.wdata, cpu.wbit);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          cur_idle = 1'b0;
        end else begin
          e = idle_e(1'b0, 1'b0, m_err);
          cur_idle = 1'b1;
        end
        chk("ram_CS",       32'(ram_CS),       32'(e.cs));
        chk("ram_RW",       32'(ram_RW),       32'(e.rw));
        chk("ram_Bb",       32'(ram_Bb),       32'(e.bb));
        chk("ram_addr",     32'(ram_addr),     32'(e.addr));
        chk("ram_position", 32'(ram_position), 32'(e.pos));
        chk("ram_din",      32'(ram_din),      32'(e.din));
        chk("ram_bin",      32'(ram_bin),      32'(e.bin));
        chk("busy",         32'(cpu.busy),     32'(e.busy));
        chk("done",         32'(cpu.done),     32'(e.done));
        chk("err",          32'(cpu.err),      32'(e.err));
        chk("rdata",        32'(cpu.rdata),    32'(e.rdata));
        chk("rbit",         32'(cpu.rbit),     32'(e.rbit));
      end
    end
  end

  // Issues one request; lat counts cycles from the accept edge to the done cycle
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] wd,
                       input logic wb, input int hold, output int lat, output logic err_d);
    @(negedge clk);
    cpu.op = op; cpu.baddr = a; cpu.wdata = wd; cpu.wbit = wb; cpu.req = 1'b1;
    @(posedge clk);
    lat = 0;
    err_d = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i >= hold) cpu.req = 1'b0;
      if (cpu.done) begin
        lat = i;
        err_d = cpu.err;
        break;
      end
    end
    cpu.req = 1'b0;
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int   lat;
    logic errd;
    int   cs0;
    cpu.req = 1'b0; cpu.op = 3'd0; cpu.baddr = 8'h00; cpu.wdata = 8'h00; cpu.wbit = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy",  32'(cpu.busy),  0);
    chk("rst_done",  32'(cpu.done),  0);
    chk("rst_err",   32'(cpu.err),   0);
    chk("rst_rdata", 32'(cpu.rdata), 0);
    chk("rst_cs",    32'(ram_CS),    1);

    do_op(3'd1, 8'h45, 8'hA5, 1'b0, 1, lat, errd);
    chk("bwr_lat",  32'(lat),     2);
    chk("bwr_addr", 32'(wr_addr), 'h45);
    chk("bwr_din",  32'(wr_din),  'hA5);
    chk("bwr_bb",   32'(wr_bb),   1);
    do_op(3'd0, 8'h45, 8'h00, 1'b0, 1, lat, errd);
    chk("brd_lat",   32'(lat),       3);
    chk("brd_rdata", 32'(cpu.rdata), 'hA5);
    chk("brd_err",   32'(errd),      0);

    // reset during the first RD cycle of a byte read
    @(negedge clk);
    cpu.op = 3'd0; cpu.baddr = 8'h45; cpu.req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu.req = 1'b0;
    chk("mid_rd_cs", 32'(ram_CS), 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_cs",    32'(ram_CS),    1);
    chk("mrst_busy",  32'(cpu.busy),  0);
    chk("mrst_done",  32'(cpu.done),  0);
    chk("mrst_rdata", 32'(cpu.rdata), 0);

    do_op(3'd3, 8'h1B, 8'h00, 1'b1, 1, lat, errd);
    chk("twr_lat",  32'(lat),     2);
    chk("twr_addr", 32'(wr_addr), 'h23);
    chk("twr_pos",  32'(wr_pos),  'h08);
    chk("twr_bb",   32'(wr_bb),   0);
    chk("twr_bin",  32'(wr_bin),  1);
    do_op(3'd2, 8'h1B, 8'h00, 1'b0, 1, lat, errd);
    chk("trd_lat",  32'(lat),      3);
    chk("trd_rbit", 32'(cpu.rbit), 1);

    do_op(3'd4, 8'h00, 8'h00, 1'b0, 1, lat, errd);
    chk("cpl1_lat",  32'(lat),      4);
    chk("cpl1_rbit", 32'(cpu.rbit), 0);
    chk("cpl1_bin",  32'(wr_bin),   1);
    chk("cpl1_addr", 32'(wr_addr),  'h20);
    chk("cpl1_pos",  32'(wr_pos),   'h01);
    do_op(3'd4, 8'h00, 8'h00, 1'b0, 1, lat, errd);
    chk("cpl2_rbit", 32'(cpu.rbit), 1);
    chk("cpl2_bin",  32'(wr_bin),   0);

    do_op(3'd1, 8'h7F, 8'hFF, 1'b0, 1, lat, errd);
    do_op(3'd5, 8'h7F, 8'h00, 1'b0, 1, lat, errd);
    chk("inc_lat",   32'(lat),       4);
    chk("inc_rdata", 32'(cpu.rdata), 'hFF);
    chk("inc_din",   32'(wr_din),    'h00);
    do_op(3'd6, 8'h10, 8'h00, 1'b0, 1, lat, errd);
    chk("dec_rdata", 32'(cpu.rdata), 'h00);
    chk("dec_din",   32'(wr_din),    'hFF);

    cs0 = cs_cnt;
    do_op(3'd0, 8'h80, 8'h00, 1'b0, 1, lat, errd);
    chk("flt_byte_lat", 32'(lat),  1);
    chk("flt_byte_err", 32'(errd), 1);
    do_op(3'd2, 8'h90, 8'h00, 1'b0, 1, lat, errd);
    chk("flt_bit_lat", 32'(lat),  1);
    chk("flt_bit_err", 32'(errd), 1);
    do_op(3'd7, 8'h05, 8'h00, 1'b0, 1, lat, errd);
    chk("flt_op_lat", 32'(lat),  1);
    chk("flt_op_err", 32'(errd), 1);
    chk("flt_no_cs",  32'(cs_cnt - cs0), 0);
    chk("flt_rdata_hold", 32'(cpu.rdata), 'h00);

    // request held high through the busy window of an increment
    cs0 = cs_cnt;
    do_op(3'd5, 8'h7F, 8'h00, 1'b0, 3, lat, errd);
    chk("hold_lat", 32'(lat),  4);
    chk("hold_err", 32'(errd), 0);
    repeat (3) @(negedge clk);
    chk("hold_cs_cycles", 32'(cs_cnt - cs0), RDL + 1);
    chk("hold_idle",      32'(cpu.busy),     0);
    do_op(3'd0, 8'h7F, 8'h00, 1'b0, 1, lat, errd);
    chk("hold_single_inc", 32'(cpu.rdata), 'h01);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
